// File: rtl/puf_pkg.sv
// Shared types, constants and helper functions for the arbiter PUF model.
package puf_pkg;

  localparam logic [31:0] GOLDEN = 32'h9E3779B9;
  localparam int          WW     = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } puf_state_t;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // Wide enough that n stages of 8-bit weights can never overflow.
  function automatic int acc_width(input int n);
    return WW + $clog2(n) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/test_if.sv
// Launch/challenge/response bundle of the arbiter PUF.
// Protocol: a 0->1 on in while state==ST_IDLE launches; sel is sampled on that
// edge; out is updated N edges later and held; state==ST_BUSY while evaluating.
interface test_if #(parameter int N = 128);
  logic                in;
  logic [N-1:0]        sel;
  logic                out;
  puf_pkg::puf_state_t state;

  modport master (output in, sel, input out, state);
  modport slave  (input in, sel, output out, state);
endinterface

// File: rtl/puf_weight_gen.sv
// Combinational per-stage delay weights derived from the instance seed.
module puf_weight_gen
  import puf_pkg::*;
#(
  parameter int          CW   = 7,
  parameter logic [31:0] SEED = 32'hACE12024
) (
  input  logic [CW-1:0]        k,
  output logic signed [WW-1:0] ws,
  output logic signed [WW-1:0] wc
);

  logic [31:0] x;
  logic        unused_hi;

  always_comb begin
    x = xorshift32(SEED ^ (32'(k) * GOLDEN));
  end

  assign ws        = x[7:0];
  assign wc        = x[15:8];
  assign unused_hi = ^x[31:16];

endmodule

// File: rtl/test.sv
// N-stage arbiter PUF: one switch stage per clock, arbiter resolves the sign of
// the accumulated delay difference into a held response bit.
module test
  import puf_pkg::*;
#(
  parameter int          N    = 128,
  parameter logic [31:0] SEED = 32'hACE12024
) (
  input  logic clk,
  input  logic reset,
  test_if.slave bus
);

  localparam int AW = acc_width(N);
  localparam int CW = cnt_width(N);

  logic                  in_q;
  logic [N-1:0]          chal_q;
  logic [CW-1:0]         cnt;
  logic signed [AW-1:0]  d;
  logic signed [AW-1:0]  d_next;
  logic signed [WW-1:0]  ws;
  logic signed [WW-1:0]  wc;
  puf_state_t            state_q;
  puf_state_t            state_d;
  logic                  launch;
  logic                  last;

  puf_weight_gen #(
    .CW   (CW),
    .SEED (SEED)
  ) u_wgen (
    .k  (cnt),
    .ws (ws),
    .wc (wc)
  );

  assign launch    = bus.in && !in_q;
  assign last      = (cnt == CW'(N - 1));
  assign bus.state = state_q;

  // Cross stage swaps the two racing paths, which negates the difference so far.
  always_comb begin
    d_next = chal_q[cnt] ? (-d + AW'(wc)) : (d + AW'(ws));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_BUSY;
      ST_BUSY: if (last)   state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= 1'b0;
      chal_q  <= '0;
      cnt     <= '0;
      d       <= '0;
      bus.out <= 1'b0;
    end else begin
      in_q <= bus.in;
      if (state_q == ST_IDLE) begin
        if (launch) begin
          chal_q <= bus.sel;
          cnt    <= '0;
          d      <= '0;
        end
      end else begin
        d   <= d_next;
        cnt <= cnt + CW'(1);
        // A tie resolves to 0.
        if (last) bus.out <= (d_next > 0);
      end
    end
  end

endmodule

// File: tb/tb_test.sv
// Directed bench for the arbiter PUF: single-stage golden table plus
// multi-cycle sequences on 128-stage instances with two different seeds.
module tb_test;
  import puf_pkg::*;

  localparam int          NA = 128;
  localparam logic [31:0] S1 = 32'hACE12024;
  localparam logic [31:0] S2 = 32'h2;

  logic clk;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  test_if #(.N(NA)) ifa ();
  test_if #(.N(NA)) ifb ();
  test_if #(.N(1))  if1 ();

  assign ifb.in  = ifa.in;
  assign ifb.sel = ifa.sel;

  test #(.N(NA), .SEED(S1))    dut_a (.clk(clk), .reset(rst_n), .bus(ifa.slave));
  test #(.N(NA), .SEED(S2))    dut_b (.clk(clk), .reset(rst_n), .bus(ifb.slave));
  test #(.N(1),  .SEED(32'h1)) dut_1 (.clk(clk), .reset(rst_n), .bus(if1.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  sel;
    logic  exp;
    string nm;
  } vec1_t;

  vec1_t vec1 [2];

  logic prev_a;
  logic prev_1;

  function automatic logic model(input logic [NA-1:0] c, input logic [31:0] seed, input int n);
    int          dd;
    int          ws;
    int          wc;
    logic [31:0] x;
    dd = 0;
    for (int k = 0; k < n; k++) begin
      x  = seed ^ (32'(k) * 32'h9E3779B9);
      x  = x ^ (x << 13);
      x  = x ^ (x >> 17);
      x  = x ^ (x << 5);
      ws = int'($signed(x[7:0]));
      wc = int'($signed(x[15:8]));
      dd = c[k] ? (wc - dd) : (dd + ws);
    end
    return (dd > 0);
  endfunction

  function automatic logic [NA-1:0] rand_chal();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NA-1:0] pick(input logic want);
    logic [NA-1:0] c;
    c = rand_chal();
    for (int t = 0; t < 1000; t++) begin
      if (model(c, S1, NA) == want) break;
      c = rand_chal();
    end
    return c;
  endfunction

  // scoreboard
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver: called on a negedge; launch edge T is the next posedge
  task automatic launch_a(input logic [NA-1:0] c, input string nm);
    logic e;
    e = model(c, S1, NA);
    ifa.sel = c;
    ifa.in  = 1'b1;
    @(negedge clk);
    ifa.in = 1'b0;
    repeat (NA - 1) @(negedge clk);
    check({nm, "_pre"}, ifa.out, prev_a);
    @(negedge clk);
    check(nm, ifa.out, e);
    prev_a = e;
  endtask

  task automatic launch_1(input vec1_t v);
    if1.sel = v.sel;
    if1.in  = 1'b1;
    @(negedge clk);
    if1.in = 1'b0;
    check({v.nm, "_pre"}, if1.out, prev_1);
    @(negedge clk);
    check(v.nm, if1.out, v.exp);
    prev_1 = v.exp;
  endtask

  initial begin
    logic [NA-1:0] s1;
    logic [NA-1:0] s2;
    logic [NA-1:0] c;
    logic          m1;
    logic          r1;
    logic          rb;
    int            diffs;

    vec1[0] = '{sel: 1'b0, exp: 1'b1, nm: "n1_sel0"};
    vec1[1] = '{sel: 1'b1, exp: 1'b1, nm: "n1_sel1"};

    ifa.in  = 1'b0;
    ifa.sel = '0;
    if1.in  = 1'b0;
    if1.sel = '0;
    rst_n   = 1'b0;
    prev_a  = 1'b0;
    prev_1  = 1'b0;
    diffs   = 0;

    // reset held with inputs toggling
    repeat (8) begin
      @(negedge clk);
      ifa.in  = 1'($urandom_range(0, 1));
      ifa.sel = rand_chal();
      if1.in  = 1'($urandom_range(0, 1));
      if1.sel = 1'($urandom_range(0, 1));
      check("rst_out_a", ifa.out, 0);
      check("rst_out_1", if1.out, 0);
      check("rst_state_a", ifa.state, ST_IDLE);
    end
    ifa.in = 1'b0;
    if1.in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("n1_before_launch", if1.out, 0);

    // single-stage golden table
    for (int i = 0; i < 2; i++) launch_1(vec1[i]);

    // first launch after reset, exact latency via the _pre check
    launch_a(pick(1'b1), "post_reset");

    // determinism and seed diversity
    for (int j = 0; j < 20; j++) begin
      c = rand_chal();
      launch_a(c, "det_first");
      r1 = ifa.out;
      rb = ifb.out;
      check("seed2_model", rb, model(c, S2, NA));
      launch_a(c, "det_second");
      check("det_repeat", ifa.out, r1);
      if (rb !== r1) diffs++;
    end
    check("seed_diversity", (diffs > 0), 1);

    // second rise and sel change while busy
    s1 = pick(~prev_a);
    m1 = model(s1, S1, NA);
    s2 = pick(~m1);
    ifa.sel = s1;
    ifa.in  = 1'b1;
    @(negedge clk);
    ifa.in = 1'b0;
    repeat (4) @(negedge clk);
    ifa.in  = 1'b1;
    ifa.sel = s2;
    @(negedge clk);
    ifa.in = 1'b0;
    repeat (NA - 6) @(negedge clk);
    check("busy_pre", ifa.out, prev_a);
    @(negedge clk);
    check("busy_result", ifa.out, m1);
    repeat (NA + 10) @(negedge clk);
    check("busy_no_extra", ifa.out, m1);
    check("busy_state_idle", ifa.state, ST_IDLE);
    prev_a = m1;

    // in held high for 3N cycles
    s1 = pick(~prev_a);
    m1 = model(s1, S1, NA);
    s2 = pick(~m1);
    ifa.sel = s1;
    ifa.in  = 1'b1;
    @(negedge clk);
    ifa.sel = s2;
    repeat (NA - 1) @(negedge clk);
    check("hold_pre", ifa.out, prev_a);
    @(negedge clk);
    check("hold_result", ifa.out, m1);
    repeat (2 * NA) @(negedge clk);
    check("hold_single_eval", ifa.out, m1);
    check("hold_state_idle", ifa.state, ST_IDLE);
    ifa.in = 1'b0;
    prev_a = m1;
    @(negedge clk);

    // reset mid-evaluation
    if (prev_a !== 1'b1) launch_a(pick(1'b1), "abort_setup");
    ifa.sel = pick(1'b1);
    ifa.in  = 1'b1;
    @(negedge clk);
    ifa.in = 1'b0;
    repeat (NA / 2 - 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_async_out", ifa.out, 0);
    check("abort_state", ifa.state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NA) @(negedge clk);
    check("abort_no_update", ifa.out, 0);
    check("abort_state_idle", ifa.state, ST_IDLE);
    prev_a = 1'b0;
    prev_1 = 1'b0;
    launch_a(pick(1'b1), "after_abort");

    // back-to-back launches at T and T+N+1
    s1 = pick(~prev_a);
    m1 = model(s1, S1, NA);
    s2 = pick(~m1);
    launch_a(s1, "b2b_first");
    launch_a(s2, "b2b_second");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test.md
Name: test

Overview:
- Synthesizable, clocked digital model of an N-stage arbiter PUF (physically unclonable function).
- A launch on input `in` starts a race through N switch stages steered by the challenge `sel`.
- The signed delay difference is accumulated one stage per clock. The arbiter resolves it to a single response bit `out`.
- Used as a deterministic, per-instance PUF stand-in for challenge/response experiments. Per-instance variation comes from the SEED parameter.

Parameters:
- N, 128, number of switch stages = challenge width (legal 1..1024).
- SEED, 32'hACE12024, instance "fingerprint" from which all stage delays are derived.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in  input  1  launch signal; a 0→1 transition starts one evaluation.
- sel  input  N  challenge; bit i steers stage i (0 = straight, 1 = cross).
- out  output  1  response bit, registered, held between evaluations.

Behaviour:
- Reset (reset=0, asynchronous): out=0, busy=0, stage counter=0, accumulator=0, registered copy in_q=0. Reset mid-evaluation aborts the evaluation; no result is produced.
- Launch: at a rising clk edge T with in=1, in_q=0 and busy=0, the block does all of the following:
  - captures sel into chal_q;
  - clears the accumulator D and counter i;
  - sets busy=1.
  - in_q <= in every cycle.
- Launch conditions ignored: a rising edge of in while busy=1; a falling edge of in; in held high.
- sel changes after T do not affect the running evaluation.
- Stage weights (pure function of SEED and stage index k):
  - x = SEED ^ (k * 32'h9E3779B9), mod 2^32.
  - x ^= x<<13; x ^= x>>17; x ^= x<<5 (32-bit logical shifts).
  - ws[k] = signed x[7:0]; wc[k] = signed x[15:8].
- Evaluation: edges T+1 … T+N process stage i = 0..N-1, one per edge:
  - D_next = chal_q[i] ? (−D + wc[i]) : (D + ws[i]).
  - D is signed, width 8+$clog2(N)+1, and cannot overflow.
- Result: at edge T+N (last stage), out <= (D_next > 0) ? 1 : 0. A tie (D_next == 0) gives 0. busy then clears.
- A new launch is accepted from edge T+N+1 onward.
- Latency: out reflects the challenge N clock edges after the launch edge.
- out is unchanged at all other times.
- Determinism: same SEED, N and challenge always give the same out.

Decomposition:
- Package puf_pkg holds:
  - the golden-ratio constant 32'h9E3779B9;
  - the xorshift32 function;
  - the weight-width constant (8);
  - a function returning the accumulator width for N.
- One natural sub-module, puf_weight_gen: combinational, k → {ws, wc}, driven by the stage counter.
- The top level holds the edge detector, challenge register, counter/busy control, accumulator and arbiter output register.

Test Plan:
- Reset: reset=0 with in toggling and random sel → out stays 0 and no evaluation starts. Release reset, launch → out updates exactly N edges after the launch edge.
- Single-stage golden check, N=1, SEED=32'h1 (stage 0: x=0x00042021, ws=+33, wc=+32):
  - sel=0 → D=33 → out=1;
  - sel=1 → D=32 → out=1.
  - Also check out is 0 before the first launch.
- Determinism/diversity, default N=128:
  - 20 random challenges, each launched twice → identical out per challenge;
  - the same set with SEED=32'h2 → at least one response differs.
- Busy/launch rules: second 0→1 on in during an evaluation, plus sel changed mid-evaluation → response matches the first captured challenge only; no extra result. Holding in=1 for 3N cycles → one evaluation only.
- Reset mid-operation: assert reset at launch+N/2 → out=0 immediately (asynchronous), and no update occurs at launch+N. A new launch after release evaluates normally.
- Back-to-back: launch at T, next launch at T+N+1 with a different sel → both results appear at T+N and T+2N+1 and match the golden model.
